// File: rtl/fsk_symbol_sequencer.sv
// fsk_symbol_sequencer: serialises 16-bit UART words MSB-first into timed FSK symbols.
// Optional macro FSK_PREAMBLE_EN prepends an 8'hAA preamble to frames started from IDLE.
module fsk_symbol_sequencer #(
  parameter int SYM_CLKS     = 1200,
  parameter int LOCK_TIMEOUT = 4800,
  parameter int NBITS        = 16
) (
  input  logic             clk_12mhz_int,
  input  logic             M_RESET_B,
  input  logic [NBITS-1:0] data_in,
  input  logic             data_valid,
  input  logic             pll_locked,
  output logic             freq_select,
  output logic             wave_enable,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  output logic             lock_err
);

`ifdef FSK_PREAMBLE_EN
  localparam int PRE_BITS = 8;
  localparam logic [PRE_BITS-1:0] PREAMBLE = 8'hAA;
`else
  localparam int PRE_BITS = 0;
`endif
  localparam int SHW = NBITS + PRE_BITS;
  localparam int STW = $clog2(LOCK_TIMEOUT);
  localparam logic [15:0]    SYM_LAST    = 16'(SYM_CLKS - 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SYMBOL} state_t;

  state_t           state;
  logic             dv_q;
  logic             lk_meta;
  logic             lk_s;
  logic [SHW-1:0]   shreg;
  logic [4:0]       bits_left;
  logic [15:0]      sym_cnt;
  logic [STW-1:0]   settle_cnt;
  logic [NBITS-1:0] pend_word;
  logic             pend_valid;

  logic             rise;
  logic             stop_cmd;
  logic             word_cmd;
  logic             next_bit;
  logic             frame_end;
  logic             timeout;
  logic [NBITS-1:0] back_word;

  assign rise      = data_valid & ~dv_q;
  assign stop_cmd  = rise & (data_in == '0);
  assign word_cmd  = rise & (data_in != '0);
  assign next_bit  = shreg[SHW-2];
  assign frame_end = (state == SYMBOL) && (sym_cnt == 16'd0) && (bits_left == 5'd1);
  assign timeout   = (state == SETTLE) && !lk_s && (settle_cnt == SETTLE_LAST);
  // A word landing exactly on an empty frame end chains straight on instead of being stranded
  assign back_word = pend_valid ? pend_word : data_in;

  always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
    if (!M_RESET_B) begin
      state       <= IDLE;
      dv_q        <= 1'b0;
      lk_meta     <= 1'b0;
      lk_s        <= 1'b0;
      shreg       <= '0;
      bits_left   <= '0;
      sym_cnt     <= '0;
      settle_cnt  <= '0;
      pend_word   <= '0;
      pend_valid  <= 1'b0;
      freq_select <= 1'b0;
      wave_enable <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      dv_q       <= data_valid;
      lk_meta    <= pll_locked;
      lk_s       <= lk_meta;
      frame_done <= 1'b0;
      if (stop_cmd) begin
        state       <= IDLE;
        busy        <= 1'b0;
        wave_enable <= 1'b0;
        pend_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (word_cmd) begin
`ifdef FSK_PREAMBLE_EN
              shreg       <= {PREAMBLE, data_in};
              freq_select <= PREAMBLE[PRE_BITS-1];
`else
              shreg       <= data_in;
              freq_select <= data_in[NBITS-1];
`endif
              bits_left   <= 5'(SHW);
              settle_cnt  <= '0;
              wave_enable <= 1'b1;
              busy        <= 1'b1;
              state       <= SETTLE;
            end
          end
          SETTLE: begin
            settle_cnt <= settle_cnt + 1'b1;
            if (lk_s) begin
              sym_cnt <= SYM_LAST;
              state   <= SYMBOL;
            end else if (timeout) begin
              lock_err    <= 1'b1;
              wave_enable <= 1'b0;
              busy        <= 1'b0;
              pend_valid  <= 1'b0;
              state       <= IDLE;
            end
          end
          SYMBOL: begin
            if (sym_cnt != 16'd0) begin
              sym_cnt <= sym_cnt - 1'b1;
            end else if (bits_left > 5'd1) begin
              shreg       <= shreg << 1;
              freq_select <= next_bit;
              bits_left   <= bits_left - 1'b1;
              // Only a frequency change needs the PLL to relock
              if (next_bit != freq_select) begin
                settle_cnt <= '0;
                state      <= SETTLE;
              end else begin
                sym_cnt <= SYM_LAST;
              end
            end else if (pend_valid || word_cmd) begin
`ifdef FSK_PREAMBLE_EN
              shreg <= {back_word, {PRE_BITS{1'b0}}};
`else
              shreg <= back_word;
`endif
              freq_select <= back_word[NBITS-1];
              bits_left   <= 5'(NBITS);
              settle_cnt  <= '0;
              pend_valid  <= 1'b0;
              state       <= SETTLE;
            end else begin
              wave_enable <= 1'b0;
              busy        <= 1'b0;
              frame_done  <= 1'b1;
              state       <= IDLE;
            end
          end
          default: begin
            wave_enable <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        endcase
        // Placed after the case so a word arriving as the slot empties overrides the clear
        if (word_cmd && (state != IDLE) && !timeout && !(frame_end && !pend_valid)) begin
          if (!pend_valid || frame_end) begin
            pend_word  <= data_in;
            pend_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// tb_fsk_symbol_sequencer: directed and randomised frames checked against a run-length
// reference of the expected on-air waveform. Honours FSK_PREAMBLE_EN like the design.
module tb_fsk_symbol_sequencer;

  localparam int SYM = 4;
  localparam int LTO = 16;
`ifdef FSK_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  typedef struct {
    logic we;
    logic fs;
    logic bz;
    logic fd;
    bit   fs_chk;
    bit   set_lerr;
    bit   clr_pend;
  } samp_t;

  logic        clk_12mhz_int = 1'b0;
  logic        M_RESET_B     = 1'b0;
  logic [15:0] data_in       = '0;
  logic        data_valid    = 1'b0;
  logic        pll_locked    = 1'b1;
  logic        freq_select, wave_enable, busy, frame_done, overflow, lock_err;

  samp_t       exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  bit          exp_ovf     = 0;
  bit          exp_lerr    = 0;
  bit          ovf_next    = 0;
  bit          pend_full   = 0;
  bit          last_bz     = 0;
  bit          hold_unlock = 0;
  int          lcnt        = 3;
  logic        last_fs     = 1'b0;
  logic [7:0]  pre_pat     = 8'hAA;

  fsk_symbol_sequencer #(.SYM_CLKS(SYM), .LOCK_TIMEOUT(LTO), .NBITS(16)) dut (
    .clk_12mhz_int (clk_12mhz_int),
    .M_RESET_B     (M_RESET_B),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .pll_locked    (pll_locked),
    .freq_select   (freq_select),
    .wave_enable   (wave_enable),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .lock_err      (lock_err)
  );

  always #5 clk_12mhz_int = ~clk_12mhz_int;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  // Every run of equal bits costs one relock cycle plus SYM cycles per bit; the synchronised
  // lock is still high from the previous symbol at this symbol length, so relock takes one cycle
  function automatic void push_frame(input logic [15:0] w, input bit with_pre, input bit from_pend);
    bit    bq[$];
    samp_t s;
    int    i, run;
    bit    first;
    if (with_pre) for (int k = 7; k >= 0; k--) bq.push_back(pre_pat[k]);
    for (int k = 15; k >= 0; k--) bq.push_back(w[k]);
    i = 0;
    first = 1;
    while (i < bq.size()) begin
      run = 1;
      while ((i + run < bq.size()) && (bq[i+run] == bq[i])) run++;
      for (int c = 0; c < 1 + SYM * run; c++) begin
        s = '{1'b1, bq[i], 1'b1, 1'b0, 1'b1, 1'b0, from_pend && first};
        exp_q.push_back(s);
        first = 0;
      end
      i += run;
    end
  endfunction

  function automatic void push_end();
    samp_t s;
    s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(s);
  endfunction

  function automatic void push_abort(input logic [15:0] w);
    samp_t s;
    logic  fb;
    fb = PRE_EN ? pre_pat[7] : w[15];
    for (int c = 0; c < LTO; c++) begin
      s = '{1'b1, fb, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_q.push_back(s);
    end
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(s);
  endfunction

  // Updates the expected waveform for a data_valid rise seen at the coming clock edge
  function automatic void model_rise(input logic [15:0] w);
    if (w == 16'h0000) begin
      exp_q.delete();
      pend_full = 0;
    end else if (!last_bz) begin
      if (hold_unlock) push_abort(w);
      else begin
        push_frame(w, PRE_EN, 1'b0);
        push_end();
      end
    end else if (!pend_full) begin
      exp_q.delete(exp_q.size() - 1);
      push_frame(w, 1'b0, 1'b1);
      push_end();
      pend_full = 1;
    end else begin
      ovf_next = 1;
    end
  endfunction

  // PLL stand-in: LOCKED drops on a frequency change and returns three cycles later
  task automatic pll_update();
    if (hold_unlock || (freq_select !== last_fs)) begin
      lcnt = 0;
      pll_locked = 1'b0;
    end else begin
      if (lcnt < 3) lcnt++;
      pll_locked = (lcnt >= 3);
    end
    last_fs = freq_select;
  endtask

  task automatic check_output();
    samp_t s;
    @(posedge clk_12mhz_int);
    #1;
    cyc++;
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (exp_q.size() > 0) s = exp_q.pop_front();
    if (s.set_lerr) begin
      exp_lerr = 1;
      pend_full = 0;
    end
    if (s.clr_pend) pend_full = 0;
    if (ovf_next) begin
      exp_ovf = 1;
      ovf_next = 0;
    end
    check_bit("wave_enable", wave_enable, s.we);
    check_bit("busy", busy, s.bz);
    check_bit("frame_done", frame_done, s.fd);
    if (s.fs_chk) check_bit("freq_select", freq_select, s.fs);
    check_bit("overflow", overflow, exp_ovf);
    check_bit("lock_err", lock_err, exp_lerr);
    last_bz = s.bz;
    pll_update();
  endtask

  task automatic apply_stimulus(input logic [15:0] w, input int hold);
    data_in = w;
    data_valid = 1'b1;
    model_rise(w);
    repeat (hold) check_output();
    data_valid = 1'b0;
    check_output();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) check_output();
    repeat (10) check_output();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_freq"}, freq_select, 1'b0);
    check_bit({tag, "_wave"}, wave_enable, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, frame_done, 1'b0);
    check_bit({tag, "_ovf"}, overflow, 1'b0);
    check_bit({tag, "_lerr"}, lock_err, 1'b0);
  endtask

  task automatic do_reset();
    #2 M_RESET_B = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clk_12mhz_int);
    #1 M_RESET_B = 1'b1;
    exp_q.delete();
    exp_ovf = 0;
    exp_lerr = 0;
    ovf_next = 0;
    pend_full = 0;
    last_bz = 0;
  endtask

  initial begin
    logic [15:0] w1, w2, w3;
    int          mode, gap;

    #3 check_reset_outputs("por");
    @(posedge clk_12mhz_int);
    #1 M_RESET_B = 1'b1;
    repeat (10) check_output();

    $display("[TB] single frame 8001 and constant FFFF");
    apply_stimulus(16'h8001, 1);
    drain();
    apply_stimulus(16'hFFFF, 1);
    drain();

    $display("[TB] back-to-back frame and overflow");
    apply_stimulus(16'h00FF, 1);
    repeat (10) check_output();
    apply_stimulus(16'hF000, 2);
    apply_stimulus(16'h1234, 1);
    drain();

    $display("[TB] STOP during symbol 5");
    apply_stimulus(16'h5555, 1);
    repeat (20) check_output();
    apply_stimulus(16'h0000, 1);
    drain();

    $display("[TB] lock timeout");
    hold_unlock = 1;
    repeat (6) check_output();
    apply_stimulus(16'h0001, 1);
    drain();
    hold_unlock = 0;
    repeat (10) check_output();

    $display("[TB] reset mid-frame");
    apply_stimulus(16'hA5C3, 1);
    repeat (15) check_output();
    do_reset();
    repeat (10) check_output();

    $display("[TB] data_valid held for 50 cycles");
    apply_stimulus(16'h0003, 50);
    drain();

    $display("[TB] randomised frames");
    for (int it = 0; it < 12; it++) begin
      w1   = 16'($urandom_range(1, 65535));
      w2   = 16'($urandom_range(1, 65535));
      w3   = 16'($urandom_range(1, 65535));
      mode = $urandom_range(0, 4);
      gap  = $urandom_range(0, 30);
      apply_stimulus(w1, 1);
      repeat (gap) check_output();
      if (mode == 1 || mode == 2 || mode == 4) apply_stimulus(w2, $urandom_range(1, 3));
      if (mode == 2) apply_stimulus(w3, $urandom_range(1, 3));
      if (mode == 4) repeat ($urandom_range(0, 10)) check_output();
      if (mode == 3 || mode == 4) apply_stimulus(16'h0000, 1);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
